// File: rtl/main_memory_model.sv
// Main-memory responder for icache line fills and dcache line reads/writes.
// Latency: response pulse LATENCY cycles after acceptance, then one IDLE cycle before the next acceptance.
// Backpressure: requests are level-held by the caches; the model accepts only in IDLE, and dcache wins ties.
module main_memory_model #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128,
    parameter int MEM_DEPTH  = 4096,
    parameter int LATENCY    = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ic_req_valid_miss,
    input  logic [ADDR_WIDTH-1:0] ic_req_addr_miss,
    output logic                  ic_rsp_valid_miss,
    output logic [LINE_WIDTH-1:0] ic_rsp_data_miss,
    input  logic                  dc_req_valid_miss,
    input  logic                  dc_req_we_miss,
    input  logic [ADDR_WIDTH-1:0] dc_req_addr_miss,
    input  logic [LINE_WIDTH-1:0] dc_req_data_miss,
    output logic                  dc_rsp_valid_miss,
    output logic [LINE_WIDTH-1:0] dc_rsp_data_miss,
    output logic                  busy
);

    localparam int OFF_W = $clog2(LINE_WIDTH / 8);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic {OWN_IC, OWN_DC} owner_t;

    typedef struct packed {
        owner_t                owner;
        logic                  we;
        logic [IDX_W-1:0]      idx;
        logic [LINE_WIDTH-1:0] data;
    } req_t;

    logic [LINE_WIDTH-1:0] mem [MEM_DEPTH];

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    req_t                  req_q, req_d;
    logic                  ic_rsp_vld_q, ic_rsp_vld_d;
    logic                  dc_rsp_vld_q, dc_rsp_vld_d;
    logic [LINE_WIDTH-1:0] ic_rsp_dat_q, ic_rsp_dat_d;
    logic [LINE_WIDTH-1:0] dc_rsp_dat_q, dc_rsp_dat_d;
    logic                  busy_q, busy_d;

    req_t                  tgt;
    logic                  enter_resp;
    logic                  mem_we;
    logic [LINE_WIDTH-1:0] rsp_line;
    logic                  unused_addr;

    // Only the line-index slice of each address is meaningful.
    assign unused_addr = ^{ic_req_addr_miss, dc_req_addr_miss};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        tgt          = req_q;
        enter_resp   = 1'b0;
        mem_we       = 1'b0;
        rsp_line     = '0;
        ic_rsp_vld_d = 1'b0;
        dc_rsp_vld_d = 1'b0;
        ic_rsp_dat_d = ic_rsp_dat_q;
        dc_rsp_dat_d = dc_rsp_dat_q;

        case (state_q)
            IDLE: begin
                if (dc_req_valid_miss) begin
                    tgt.owner = OWN_DC;
                    tgt.we    = dc_req_we_miss;
                    tgt.idx   = dc_req_addr_miss[OFF_W +: IDX_W];
                    tgt.data  = dc_req_data_miss;
                end else if (ic_req_valid_miss) begin
                    tgt.owner = OWN_IC;
                    tgt.we    = 1'b0;
                    tgt.idx   = ic_req_addr_miss[OFF_W +: IDX_W];
                    tgt.data  = '0;
                end
                if (dc_req_valid_miss || ic_req_valid_miss) begin
                    req_d = tgt;
                    cnt_d = CNT_W'(1);
                    if (LATENCY > 1) begin
                        state_d = WAIT;
                    end else begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(LATENCY - 1)) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // The memory access happens on the edge that enters RESP, so the
        // registered response is visible throughout the RESP cycle.
        if (enter_resp) begin
            rsp_line = tgt.we ? tgt.data : mem[tgt.idx];
            mem_we   = tgt.we & reset;
            if (tgt.owner == OWN_DC) begin
                dc_rsp_vld_d = 1'b1;
                dc_rsp_dat_d = rsp_line;
            end else begin
                ic_rsp_vld_d = 1'b1;
                ic_rsp_dat_d = rsp_line;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_q        <= '0;
            ic_rsp_vld_q <= 1'b0;
            dc_rsp_vld_q <= 1'b0;
            ic_rsp_dat_q <= '0;
            dc_rsp_dat_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            ic_rsp_vld_q <= ic_rsp_vld_d;
            dc_rsp_vld_q <= dc_rsp_vld_d;
            ic_rsp_dat_q <= ic_rsp_dat_d;
            dc_rsp_dat_q <= dc_rsp_dat_d;
            busy_q       <= busy_d;
        end
    end

    // Storage is deliberately not reset; contents survive a reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[tgt.idx] <= tgt.data;
        end
    end

    assign ic_rsp_valid_miss = ic_rsp_vld_q;
    assign ic_rsp_data_miss  = ic_rsp_dat_q;
    assign dc_rsp_valid_miss = dc_rsp_vld_q;
    assign dc_rsp_data_miss  = dc_rsp_dat_q;
    assign busy              = busy_q;

endmodule

// File: doc/main_memory_model.md
Name: main_memory_model

Overview:
- Responder side of the cache miss interface: serves line-fill requests from the instruction cache and read/write requests from the data cache.
- Emulates main memory with a fixed access latency.
- Arbitrates between the two caches; the data cache has priority. One request is in flight at a time.
- Sits in core_wrapper, below both caches. It replaces the inline latency counter in the fetch stage.

Parameters:
ADDR_WIDTH, 32, byte address width of miss requests
LINE_WIDTH, 128, cache line width in bits (multiple of 8)
MEM_DEPTH, 4096, number of lines stored (power of two)
LATENCY, 10, cycles from request acceptance to response (>=1)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
ic_req_valid_miss  in  1  icache line-fill request, held until response
ic_req_addr_miss  in  ADDR_WIDTH  icache request byte address
ic_rsp_valid_miss  out  1  icache response strobe, one-cycle pulse
ic_rsp_data_miss  out  LINE_WIDTH  icache line data
dc_req_valid_miss  in  1  dcache request, held until response
dc_req_we_miss  in  1  1 = write line, 0 = read line
dc_req_addr_miss  in  ADDR_WIDTH  dcache request byte address
dc_req_data_miss  in  LINE_WIDTH  dcache write data
dc_rsp_valid_miss  out  1  dcache response/ack strobe, one-cycle pulse
dc_rsp_data_miss  out  LINE_WIDTH  dcache read data (write: data written)
busy  out  1  request in flight (state != IDLE)

Behaviour:
- Line index = addr[$clog2(LINE_WIDTH/8) +: $clog2(MEM_DEPTH)].
  - Offset bits and upper bits are ignored, so addresses wrap modulo MEM_DEPTH lines.
- Storage is an array of MEM_DEPTH x LINE_WIDTH. Reset does not clear it; the testbench preloads it hierarchically.
- Reset (reset=0, asynchronous):
  - state=IDLE, count=0, both rsp_valid=0, both rsp_data=0, busy=0.
  - Latched request fields are cleared.
  - An in-flight request is discarded: no response, and no write is performed.
- FSM states: IDLE, WAIT, RESP.
  - IDLE:
    - dc_req_valid_miss=1: latch dcache addr/we/data, owner=DC.
    - Else if ic_req_valid_miss=1: latch icache addr, owner=IC, we=0.
    - On latch: count=1; go to WAIT if LATENCY>1, else go to RESP.
    - Both valid in the same cycle: dcache wins. The icache request stays pending and is accepted in the first IDLE cycle after the dcache response.
  - WAIT: count increments each cycle; go to RESP when count==LATENCY-1. Requests are ignored in this state.
  - RESP (exactly 1 cycle):
    - Owner's rsp_valid_miss=1.
    - Read: rsp_data = mem[index].
    - Write: mem[index] <= latched data on this clock edge, and rsp_data = latched data.
    - The non-owner's rsp_valid_miss stays 0. Next state is IDLE.
- Latency: acceptance at edge N gives rsp_valid high in cycle N+LATENCY. Back-to-back throughput is one request per LATENCY+1 cycles (IDLE gap).
- rsp_data is registered and holds its last value while rsp_valid=0. The icache and dcache data outputs are independent registers.
- Requester rule: the request is held stable until its rsp pulse and is deasserted in the cycle after it. A request still high in that IDLE cycle is treated as a new request.
- Input changes during WAIT are ignored; latched values are used.
- Read-after-write: a read accepted after a write's RESP returns the new data.
- Counter width: $clog2(LATENCY+1). No overflow is possible.
- No response is ever produced without a prior acceptance. At most one rsp_valid is high in any cycle.

Test Plan:
- Icache read, LATENCY=10:
  - Stimulus: preload mem[5]=0xA5A5…; ic_req addr=0x50 accepted at edge 0.
  - Response: ic_rsp_valid high only in cycle 10 with data 0xA5A5…; dc_rsp_valid stays 0; busy high in cycles 1-10.
- Simultaneous requests:
  - Stimulus: dc read addr=0x20 and ic addr=0x30 both raised in the same cycle.
  - Response: dc_rsp at cycle 10 with mem[2]; ic accepted at cycle 11; ic_rsp at cycle 21 with mem[3].
- Write then read:
  - Stimulus: dc write addr=0x40, data=0x1234; then ic read addr=0x40.
  - Response: dc_rsp pulse with data 0x1234; ic_rsp returns 0x1234.
- Address wrap:
  - Stimulus: MEM_DEPTH=4096, LINE_WIDTH=128; read addr=0x10000 and addr=0x0.
  - Response: both reads return mem[0]; the 4 offset bits are ignored (e.g. addr=0x4F reads mem[4]).
- Reset mid-operation:
  - Stimulus: assert reset=0 at cycle 5 of a dc write to addr=0x60.
  - Response: outputs go to 0 immediately, no rsp pulse, mem[6] unchanged; a request after reset release completes normally in LATENCY cycles.
- LATENCY=1 corner:
  - Stimulus: set LATENCY=1; issue an icache read.
  - Response: rsp in the cycle after acceptance; WAIT is skipped; a back-to-back request is accepted every 2 cycles.
